// File: rtl/score_keeper_if.sv
// score_keeper_if: game-event inputs and score/status outputs of score_keeper.
interface score_keeper_if #(
    parameter int DIGITS = 4
) ();
    logic                  tick_in;
    logic                  game_start;
    logic                  game_over;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   high_score_bcd;
    logic                  running;
    logic                  new_high;

    modport master (
        output tick_in, game_start, game_over,
        input  score_bcd, high_score_bcd, running, new_high
    );

    modport slave (
        input  tick_in, game_start, game_over,
        output score_bcd, high_score_bcd, running, new_high
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: turns divided-clock ticks into a BCD score, tracks the high score, runs the game FSM.
// Define SCORE_SATURATE_EN to hold the score at all nines instead of wrapping to zero.
module score_keeper #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_POINT = 1
) (
    input  logic          sysclk,
    input  logic          reset,
    score_keeper_if.slave bus
);
    localparam int         SW       = 4 * DIGITS;
    localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_POINT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_OVER} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_tick_q;
    logic [7:0]    r_prescale;
    logic [SW-1:0] r_score;
    logic [SW-1:0] r_high;
    logic          r_new_high;

    logic          w_tick_rise;
    logic          w_clear;
    logic          w_tick_adv;
    logic          w_point_inc;
    logic          w_capture;
    logic          w_running;

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] res;
        logic          carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    res[4*d +: 4] = 4'd0;
                end else begin
                    res[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
`ifdef SCORE_SATURATE_EN
        // A carry out of the top digit means every digit was 9.
        if (carry) res = v;
`endif
        return res;
    endfunction

    assign w_tick_rise = bus.tick_in & ~r_tick_q;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_tick_adv  = 1'b0;
        w_point_inc = 1'b0;
        w_capture   = 1'b0;
        w_running   = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (bus.game_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_RUNNING;
                end
            end
            S_RUNNING: begin
                w_running = 1'b1;
                // game_over pre-empts a same-cycle tick, so the compare sees the un-incremented score.
                if (bus.game_over) begin
                    w_state_nxt = S_OVER;
                    w_capture   = (r_score > r_high);
                end else if (w_tick_rise) begin
                    w_tick_adv  = 1'b1;
                    w_point_inc = (r_prescale == PRE_LAST);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tick_q   <= 1'b1;
            r_prescale <= 8'd0;
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else begin
            r_tick_q <= bus.tick_in;
            if (w_clear) begin
                r_score    <= '0;
                r_prescale <= 8'd0;
                r_new_high <= 1'b0;
            end else begin
                if (w_tick_adv) begin
                    r_prescale <= w_point_inc ? 8'd0 : r_prescale + 8'd1;
                end
                if (w_point_inc) begin
                    r_score <= bcd_inc(r_score);
                end
                if (w_capture) begin
                    r_high     <= r_score;
                    r_new_high <= 1'b1;
                end
            end
        end
    end

    assign bus.score_bcd      = r_score;
    assign bus.high_score_bcd = r_high;
    assign bus.running        = w_running;
    assign bus.new_high       = r_new_high;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: two score_keeper instances (1 and 3 ticks per point) checked against an integer game model.
module tb_score_keeper;
    localparam int MAXV = 9999;
`ifdef SCORE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    score_keeper_if #(.DIGITS(4)) ifa ();
    score_keeper_if #(.DIGITS(4)) ifb ();

    score_keeper #(.DIGITS(4), .TICKS_PER_POINT(1)) u_dut0 (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (ifa.slave)
    );
    score_keeper #(.DIGITS(4), .TICKS_PER_POINT(3)) u_dut1 (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Game model: plain integers, 0 = idle, 1 = running, 2 = over.
    int m_score [2];
    int m_high  [2];
    int m_pre   [2];
    int m_st    [2];
    bit m_nh    [2];
    bit m_tq;
    int tpp     [2] = '{1, 3};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0;
            m_high[k]  = 0;
            m_pre[k]   = 0;
            m_st[k]    = 0;
            m_nh[k]    = 1'b0;
        end
        m_tq = 1'b1;
    endtask

    task automatic model_step(input bit t, input bit s, input bit o);
        bit rise;
        rise = t && !m_tq;
        m_tq = t;
        for (int k = 0; k < 2; k++) begin
            if (m_st[k] != 1) begin
                if (s) begin
                    m_score[k] = 0;
                    m_pre[k]   = 0;
                    m_nh[k]    = 1'b0;
                    m_st[k]    = 1;
                end
            end else if (o) begin
                if (m_score[k] > m_high[k]) begin
                    m_high[k] = m_score[k];
                    m_nh[k]   = 1'b1;
                end
                m_st[k] = 2;
            end else if (rise) begin
                m_pre[k]++;
                if (m_pre[k] == tpp[k]) begin
                    m_pre[k] = 0;
                    if (m_score[k] == MAXV) m_score[k] = SAT ? MAXV : 0;
                    else m_score[k] = m_score[k] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check_eq("d0.score", 32'(ifa.score_bcd),      32'(to_bcd(m_score[0])));
        check_eq("d0.high",  32'(ifa.high_score_bcd), 32'(to_bcd(m_high[0])));
        check_eq("d0.run",   32'(ifa.running),        32'(m_st[0] == 1));
        check_eq("d0.nh",    32'(ifa.new_high),       32'(m_nh[0]));
        check_eq("d1.score", 32'(ifb.score_bcd),      32'(to_bcd(m_score[1])));
        check_eq("d1.high",  32'(ifb.high_score_bcd), 32'(to_bcd(m_high[1])));
        check_eq("d1.run",   32'(ifb.running),        32'(m_st[1] == 1));
        check_eq("d1.nh",    32'(ifb.new_high),       32'(m_nh[1]));
    endtask

    task automatic step(input bit t, input bit s, input bit o);
        ifa.tick_in = t;  ifb.tick_in = t;
        ifa.game_start = s;  ifb.game_start = s;
        ifa.game_over = o;  ifb.game_over = o;
        @(posedge sysclk);
        model_step(t, s, o);
        @(negedge sysclk);
        check_all();
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        ifa.tick_in = 1'b1;  ifb.tick_in = 1'b1;
        ifa.game_start = 1'b0;  ifb.game_start = 1'b0;
        ifa.game_over = 1'b0;  ifb.game_over = 1'b0;
        model_reset();
        repeat (2) @(negedge sysclk);
        check_all();
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        edges(5);
        check_eq("idle.score", 32'(ifa.score_bcd), 32'h0000);
        check_eq("idle.run",   32'(ifa.running),   32'h0);

        // Game 1
        step(1'b0, 1'b1, 1'b0);
        edges(10);
        check_eq("g1.d1.score10", 32'(ifb.score_bcd), 32'h0003);
        edges(2);
        check_eq("g1.d0.score", 32'(ifa.score_bcd), 32'h0012);
        check_eq("g1.d0.run",   32'(ifa.running),   32'h1);
        step(1'b0, 1'b0, 1'b1);
        check_eq("g1.d0.high", 32'(ifa.high_score_bcd), 32'h0012);
        check_eq("g1.d1.high", 32'(ifb.high_score_bcd), 32'h0004);
        check_eq("g1.d1.nh",   32'(ifb.new_high),       32'h1);

        // Game 2: lower score
        step(1'b0, 1'b1, 1'b0);
        edges(6);
        check_eq("g2.d1.score", 32'(ifb.score_bcd), 32'h0002);
        step(1'b0, 1'b0, 1'b1);
        check_eq("g2.d1.high", 32'(ifb.high_score_bcd), 32'h0004);
        check_eq("g2.d1.nh",   32'(ifb.new_high),       32'h0);

        // Game 3: equal score on both instances
        step(1'b0, 1'b1, 1'b0);
        edges(12);
        step(1'b0, 1'b0, 1'b1);
        check_eq("g3.d0.nh",   32'(ifa.new_high),       32'h0);
        check_eq("g3.d1.nh",   32'(ifb.new_high),       32'h0);
        check_eq("g3.d0.high", 32'(ifa.high_score_bcd), 32'h0012);

        // Game 4: tick rise coincident with game_over
        step(1'b0, 1'b1, 1'b0);
        edges(41);
        step(1'b1, 1'b0, 1'b1);
        check_eq("g4.d0.score", 32'(ifa.score_bcd),      32'h0041);
        check_eq("g4.d0.high",  32'(ifa.high_score_bcd), 32'h0041);
        check_eq("g4.d1.high",  32'(ifb.high_score_bcd), 32'h0013);
        step(1'b0, 1'b0, 1'b0);
        edges(3);
        check_eq("over.frozen", 32'(ifa.score_bcd), 32'h0041);

        // start beats over in OVER; start is ignored while running
        step(1'b0, 1'b1, 1'b1);
        check_eq("restart.run", 32'(ifa.running), 32'h1);
        edges(2);
        step(1'b0, 1'b1, 1'b0);
        check_eq("run.start_ign", 32'(ifa.score_bcd), 32'h0002);

        // Asynchronous reset mid-game
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        check_eq("rst.score", 32'(ifa.score_bcd),      32'h0000);
        check_eq("rst.high",  32'(ifa.high_score_bcd), 32'h0000);
        check_eq("rst.run",   32'(ifa.running),        32'h0);
        @(negedge sysclk);
        ifa.tick_in = 1'b0;  ifb.tick_in = 1'b0;
        @(negedge sysclk);
        reset = 1'b0;

        // Randomized play
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 19) == 0);
        end

        // Wrap / saturate at all nines
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        edges(9998);
        check_eq("ovf.pre", 32'(ifa.score_bcd), 32'h9998);
        edges(3);
        check_eq("ovf.d0", 32'(ifa.score_bcd), SAT ? 32'h9999 : 32'h0001);
        step(1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
